// File: rtl/pixel_port_arbiter.sv
// Shares one pixel memory-manager port between the host (c0) and the blit engine (c1); out-of-bounds accesses are rejected locally.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise c0 has fixed priority.
module pixel_port_arbiter (
    input  logic       clock,
    input  logic       reset,

    input  logic       c0ReadRequest,
    input  logic       c0WriteRequest,
    input  logic [8:0] c0XCoord,
    input  logic [7:0] c0YCoord,
    input  logic [7:0] c0WriteData,
    output logic [7:0] c0ReadData,
    output logic       c0ReadComplete,
    output logic       c0WriteComplete,
    output logic       c0Rejected,

    input  logic       c1ReadRequest,
    input  logic       c1WriteRequest,
    input  logic [8:0] c1XCoord,
    input  logic [7:0] c1YCoord,
    input  logic [7:0] c1WriteData,
    output logic [7:0] c1ReadData,
    output logic       c1ReadComplete,
    output logic       c1WriteComplete,
    output logic       c1Rejected,

    output logic [8:0] memoryXCoord,
    output logic [7:0] memoryYCoord,
    output logic [7:0] memoryWriteData,
    output logic       memoryReadRequest,
    output logic       memoryWriteRequest,
    input  logic [7:0] memoryReadData,
    input  logic       memoryReadComplete,
    input  logic       memoryWriteComplete,

    output logic       grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_ACK    = 2'd2,
        S_REJECT = 2'd3
    } state_t;

    localparam logic [8:0] X_MAX = 9'd319;
    localparam logic [7:0] Y_MAX = 8'd239;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       op_wr_q, op_wr_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] data_q, data_d;
    logic       mem_rd_req_q, mem_rd_req_d;
    logic       mem_wr_req_q, mem_wr_req_d;
    logic       busy_q, busy_d;
    logic [7:0] c0_rd_data_q, c0_rd_data_d;
    logic [7:0] c1_rd_data_q, c1_rd_data_d;
    logic       c0_rd_cmp_q, c0_rd_cmp_d;
    logic       c0_wr_cmp_q, c0_wr_cmp_d;
    logic       c0_rej_q, c0_rej_d;
    logic       c1_rd_cmp_q, c1_rd_cmp_d;
    logic       c1_wr_cmp_q, c1_wr_cmp_d;
    logic       c1_rej_q, c1_rej_d;

    logic       c0_pend, c1_pend;
    logic       winner;
    logic       win_wr;
    logic [8:0] win_x;
    logic [7:0] win_y;
    logic [7:0] win_data;
    logic       out_of_bounds;
    logic       issue_match;

    logic       pulse_wr, pulse_rd, pulse_rej, pulse_client, load_rd;
    logic [7:0] rd_value;

    assign c0_pend = c0ReadRequest | c0WriteRequest;
    assign c1_pend = c1ReadRequest | c1WriteRequest;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_served_q, last_served_d;

    // When both clients contend, the one not served last time wins.
    always_comb begin
        winner = 1'b0;
        if (c0_pend && c1_pend) begin
            winner = ~last_served_q;
        end else if (!c0_pend) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        last_served_d = last_served_q;
        if ((state_q == S_ACK) || (state_q == S_REJECT)) begin
            last_served_d = grant_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_served_q <= 1'b1;
        end else begin
            last_served_q <= last_served_d;
        end
    end
`else
    always_comb begin
        winner = 1'b0;
        if (!c0_pend) begin
            winner = 1'b1;
        end
    end
`endif

    // A client raising both read and write gets its write served first.
    always_comb begin
        win_wr   = winner ? c1WriteRequest : c0WriteRequest;
        win_x    = winner ? c1XCoord       : c0XCoord;
        win_y    = winner ? c1YCoord       : c0YCoord;
        win_data = winner ? c1WriteData    : c0WriteData;
    end

    assign out_of_bounds = (win_x > X_MAX) || (win_y > Y_MAX);
    assign issue_match   = op_wr_q ? memoryWriteComplete : memoryReadComplete;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        op_wr_d      = op_wr_q;
        x_d          = x_q;
        y_d          = y_q;
        data_d       = data_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_wr_req_d = mem_wr_req_q;
        pulse_wr     = 1'b0;
        pulse_rd     = 1'b0;
        pulse_rej    = 1'b0;
        pulse_client = grant_q;
        load_rd      = 1'b0;
        rd_value     = memoryReadData;

        case (state_q)
            S_IDLE: begin
                if (c0_pend || c1_pend) begin
                    grant_d = winner;
                    op_wr_d = win_wr;
                    x_d     = win_x;
                    y_d     = win_y;
                    data_d  = win_data;
                    if (out_of_bounds) begin
                        state_d      = S_REJECT;
                        pulse_client = winner;
                        pulse_wr     = win_wr;
                        pulse_rd     = ~win_wr;
                        pulse_rej    = 1'b1;
                        load_rd      = ~win_wr;
                        rd_value     = 8'h00;
                    end else begin
                        state_d      = S_ISSUE;
                        mem_wr_req_d = win_wr;
                        mem_rd_req_d = ~win_wr;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_match) begin
                    state_d      = S_ACK;
                    mem_wr_req_d = 1'b0;
                    mem_rd_req_d = 1'b0;
                    pulse_wr     = op_wr_q;
                    pulse_rd     = ~op_wr_q;
                    load_rd      = ~op_wr_q;
                end
            end
            S_ACK, S_REJECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        c0_wr_cmp_d  = pulse_wr  & ~pulse_client;
        c0_rd_cmp_d  = pulse_rd  & ~pulse_client;
        c0_rej_d     = pulse_rej & ~pulse_client;
        c1_wr_cmp_d  = pulse_wr  &  pulse_client;
        c1_rd_cmp_d  = pulse_rd  &  pulse_client;
        c1_rej_d     = pulse_rej &  pulse_client;
        c0_rd_data_d = (load_rd && !pulse_client) ? rd_value : c0_rd_data_q;
        c1_rd_data_d = (load_rd &&  pulse_client) ? rd_value : c1_rd_data_q;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            data_q       <= '0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            busy_q       <= 1'b0;
            c0_rd_data_q <= 8'h00;
            c1_rd_data_q <= 8'h00;
            c0_rd_cmp_q  <= 1'b0;
            c0_wr_cmp_q  <= 1'b0;
            c0_rej_q     <= 1'b0;
            c1_rd_cmp_q  <= 1'b0;
            c1_wr_cmp_q  <= 1'b0;
            c1_rej_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            op_wr_q      <= op_wr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            data_q       <= data_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            busy_q       <= busy_d;
            c0_rd_data_q <= c0_rd_data_d;
            c1_rd_data_q <= c1_rd_data_d;
            c0_rd_cmp_q  <= c0_rd_cmp_d;
            c0_wr_cmp_q  <= c0_wr_cmp_d;
            c0_rej_q     <= c0_rej_d;
            c1_rd_cmp_q  <= c1_rd_cmp_d;
            c1_wr_cmp_q  <= c1_wr_cmp_d;
            c1_rej_q     <= c1_rej_d;
        end
    end

    assign c0ReadData         = c0_rd_data_q;
    assign c0ReadComplete     = c0_rd_cmp_q;
    assign c0WriteComplete    = c0_wr_cmp_q;
    assign c0Rejected         = c0_rej_q;
    assign c1ReadData         = c1_rd_data_q;
    assign c1ReadComplete     = c1_rd_cmp_q;
    assign c1WriteComplete    = c1_wr_cmp_q;
    assign c1Rejected         = c1_rej_q;
    assign memoryXCoord       = x_q;
    assign memoryYCoord       = y_q;
    assign memoryWriteData    = data_q;
    assign memoryReadRequest  = mem_rd_req_q;
    assign memoryWriteRequest = mem_wr_req_q;
    assign grant              = grant_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Randomized bench for pixel_port_arbiter: transaction-level client queues and a memory responder
// predict service order, completion pulses, rejected accesses and read data.
module tb_pixel_port_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       c0ReadRequest, c0WriteRequest;
    logic [8:0] c0XCoord;
    logic [7:0] c0YCoord, c0WriteData, c0ReadData;
    logic       c0ReadComplete, c0WriteComplete, c0Rejected;
    logic       c1ReadRequest, c1WriteRequest;
    logic [8:0] c1XCoord;
    logic [7:0] c1YCoord, c1WriteData, c1ReadData;
    logic       c1ReadComplete, c1WriteComplete, c1Rejected;
    logic [8:0] memoryXCoord;
    logic [7:0] memoryYCoord, memoryWriteData, memoryReadData;
    logic       memoryReadRequest, memoryWriteRequest;
    logic       memoryReadComplete, memoryWriteComplete;
    logic       grant, busy;

    always #5 clock = ~clock;

    pixel_port_arbiter dut (
        .clock(clock), .reset(reset),
        .c0ReadRequest(c0ReadRequest), .c0WriteRequest(c0WriteRequest),
        .c0XCoord(c0XCoord), .c0YCoord(c0YCoord), .c0WriteData(c0WriteData),
        .c0ReadData(c0ReadData), .c0ReadComplete(c0ReadComplete),
        .c0WriteComplete(c0WriteComplete), .c0Rejected(c0Rejected),
        .c1ReadRequest(c1ReadRequest), .c1WriteRequest(c1WriteRequest),
        .c1XCoord(c1XCoord), .c1YCoord(c1YCoord), .c1WriteData(c1WriteData),
        .c1ReadData(c1ReadData), .c1ReadComplete(c1ReadComplete),
        .c1WriteComplete(c1WriteComplete), .c1Rejected(c1Rejected),
        .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
        .memoryWriteData(memoryWriteData),
        .memoryReadRequest(memoryReadRequest), .memoryWriteRequest(memoryWriteRequest),
        .memoryReadData(memoryReadData), .memoryReadComplete(memoryReadComplete),
        .memoryWriteComplete(memoryWriteComplete),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        bit         wr;
        bit         both;
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] d;
    } op_t;

    op_t        q0[$];
    op_t        q1[$];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         model_last;
    logic [7:0] exp_rd0, exp_rd1;
    int         forced_delay = -1;
    int         forced_rdata = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input bit wr, input bit both, input int x, input int y, input int d);
        op_t o;
        o.wr   = wr;
        o.both = both;
        o.x    = 9'(x);
        o.y    = 8'(y);
        o.d    = 8'(d);
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.wr   = 1'($urandom_range(0, 1));
        o.both = o.wr && ($urandom_range(0, 3) == 0);
        o.x    = 9'($urandom_range(0, 340));
        o.y    = 8'($urandom_range(0, 250));
        o.d    = 8'($urandom);
        return o;
    endfunction

    function automatic bit is_oob(input op_t o);
        return (o.x >= 9'd320) || (o.y >= 8'd240);
    endfunction

    // Spec-level arbitration rule over whichever clients still have work queued.
    function automatic bit pick_winner();
        bit p0, p1;
        p0 = (q0.size() != 0);
        p1 = (q1.size() != 0);
`ifdef ARB_ROUND_ROBIN_EN
        if (p0 && p1) return !model_last;
`endif
        return p0 ? 1'b0 : 1'b1;
    endfunction

    task automatic drive_clients();
        if (q0.size() == 0) begin
            c0WriteRequest = 1'b0; c0ReadRequest = 1'b0;
            c0XCoord = 9'($urandom); c0YCoord = 8'($urandom); c0WriteData = 8'($urandom);
        end else begin
            c0WriteRequest = q0[0].wr; c0ReadRequest = !q0[0].wr || q0[0].both;
            c0XCoord = q0[0].x; c0YCoord = q0[0].y; c0WriteData = q0[0].d;
        end
        if (q1.size() == 0) begin
            c1WriteRequest = 1'b0; c1ReadRequest = 1'b0;
            c1XCoord = 9'($urandom); c1YCoord = 8'($urandom); c1WriteData = 8'($urandom);
        end else begin
            c1WriteRequest = q1[0].wr; c1ReadRequest = !q1[0].wr || q1[0].both;
            c1XCoord = q1[0].x; c1YCoord = q1[0].y; c1WriteData = q1[0].d;
        end
    endtask

    // Serve everything queued on both clients, acting as clients and as the memory manager.
    task automatic run_queues();
        int         since, req_cycles, delay, first_lat, budget;
        bit         seen, w, exp_wr, exp_rej;
        op_t        cur;
        logic [7:0] rdata;
        budget     = 40 * (q0.size() + q1.size()) + 20;
        first_lat  = 1;
        since      = 0;
        req_cycles = 0;
        delay      = 0;
        seen       = 1'b0;
        rdata      = 8'h00;
        drive_clients();
        w       = pick_winner();
        cur     = w ? q1[0] : q0[0];
        exp_wr  = cur.wr;
        exp_rej = is_oob(cur);
        while ((q0.size() + q1.size()) != 0 && budget > 0) begin
            @(posedge clock);
            #1;
            since++;
            budget--;
            memoryReadComplete  = 1'b0;
            memoryWriteComplete = 1'b0;
            memoryReadData      = 8'($urandom);
            if (memoryReadRequest || memoryWriteRequest) begin
                if (!seen) begin
                    check_eq("first_req_latency", 32'(since), 32'(first_lat));
                    check_eq("grant_issue", 32'(grant), 32'(w));
                    check_eq("oob_no_request", 32'(exp_rej), 32'(0));
                    seen  = 1'b1;
                    delay = (forced_delay >= 0) ? forced_delay : $urandom_range(0, 3);
                end
                req_cycles++;
                check_eq("mem_wr_req", 32'(memoryWriteRequest), 32'(exp_wr));
                check_eq("mem_rd_req", 32'(memoryReadRequest), 32'(!exp_wr));
                check_eq("mem_x", 32'(memoryXCoord), 32'(cur.x));
                check_eq("mem_y", 32'(memoryYCoord), 32'(cur.y));
                if (exp_wr) check_eq("mem_wdata", 32'(memoryWriteData), 32'(cur.d));
                // The owner wiggling its fields mid-access must not disturb the latched request.
                if (w) begin
                    c1XCoord = 9'($urandom); c1YCoord = 8'($urandom); c1WriteData = 8'($urandom);
                end else begin
                    c0XCoord = 9'($urandom); c0YCoord = 8'($urandom); c0WriteData = 8'($urandom);
                end
                if (req_cycles == delay + 1) begin
                    rdata          = (forced_rdata >= 0) ? 8'(forced_rdata) : 8'($urandom);
                    memoryReadData = rdata;
                    if (exp_wr) memoryWriteComplete = 1'b1;
                    else        memoryReadComplete  = 1'b1;
                end else if ($urandom_range(0, 1) == 1) begin
                    if (exp_wr) memoryReadComplete  = 1'b1;
                    else        memoryWriteComplete = 1'b1;
                end
            end
            if (c0ReadComplete || c0WriteComplete || c1ReadComplete || c1WriteComplete) begin
                check_eq("cmp_write", 32'(w ? c1WriteComplete : c0WriteComplete), 32'(exp_wr));
                check_eq("cmp_read", 32'(w ? c1ReadComplete : c0ReadComplete), 32'(!exp_wr));
                check_eq("cmp_loser_quiet",
                         32'(w ? (c0ReadComplete | c0WriteComplete | c0Rejected)
                               : (c1ReadComplete | c1WriteComplete | c1Rejected)), 32'(0));
                check_eq("rejected", 32'(w ? c1Rejected : c0Rejected), 32'(exp_rej));
                check_eq("busy_at_cmp", 32'(busy), 32'(1));
                check_eq("grant_at_cmp", 32'(grant), 32'(w));
                if (exp_rej) begin
                    check_eq("reject_latency", 32'(since), 32'(first_lat));
                    check_eq("reject_no_mem_req", 32'(seen), 32'(0));
                end else begin
                    check_eq("issue_cycles", 32'(req_cycles), 32'(delay + 1));
                end
                if (!exp_wr) begin
                    if (w) exp_rd1 = exp_rej ? 8'h00 : rdata;
                    else   exp_rd0 = exp_rej ? 8'h00 : rdata;
                end
                check_eq("c0_read_data", 32'(c0ReadData), 32'(exp_rd0));
                check_eq("c1_read_data", 32'(c1ReadData), 32'(exp_rd1));
                model_last = w;
                if (w) begin
                    if (q1[0].wr && q1[0].both) begin q1[0].wr = 1'b0; q1[0].both = 1'b0; end
                    else void'(q1.pop_front());
                end else begin
                    if (q0[0].wr && q0[0].both) begin q0[0].wr = 1'b0; q0[0].both = 1'b0; end
                    else void'(q0.pop_front());
                end
                drive_clients();
                since      = 0;
                first_lat  = 2;
                seen       = 1'b0;
                req_cycles = 0;
                if ((q0.size() + q1.size()) != 0) begin
                    w       = pick_winner();
                    cur     = w ? q1[0] : q0[0];
                    exp_wr  = cur.wr;
                    exp_rej = is_oob(cur);
                end
            end
        end
        check_eq("queues_drained", 32'(q0.size() + q1.size()), 32'(0));
        @(posedge clock);
        #1;
        memoryReadComplete  = 1'b0;
        memoryWriteComplete = 1'b0;
        check_eq("idle_busy", 32'(busy), 32'(0));
        check_eq("cmp_single_cycle",
                 32'(c0ReadComplete | c0WriteComplete | c1ReadComplete | c1WriteComplete), 32'(0));
    endtask

    initial begin
        reset               = 1'b1;
        memoryReadData      = 8'h00;
        memoryReadComplete  = 1'b0;
        memoryWriteComplete = 1'b0;
        model_last          = 1'b1;
        exp_rd0             = 8'h00;
        exp_rd1             = 8'h00;
        drive_clients();
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_grant", 32'(grant), 32'(0));
        check_eq("rst_mem_req", 32'({memoryReadRequest, memoryWriteRequest}), 32'(0));
        check_eq("rst_completes",
                 32'({c0ReadComplete, c0WriteComplete, c1ReadComplete, c1WriteComplete}), 32'(0));
        check_eq("rst_rejected", 32'({c0Rejected, c1Rejected}), 32'(0));
        check_eq("rst_read_data", 32'({c0ReadData, c1ReadData}), 32'(0));
        check_eq("rst_mem_fields", 32'({memoryXCoord, memoryYCoord, memoryWriteData}), 32'(0));
        reset = 1'b0;

        // Both clients hammering writes straight out of reset.
        for (int i = 0; i < 4; i++) q0.push_back(mk(1, 0, 20 + i, 30, i));
        for (int i = 0; i < 2; i++) q1.push_back(mk(1, 0, 100 + i, 40, 8'h80 + i));
        run_queues();

        forced_delay = 1;
        q0.push_back(mk(1, 0, 10, 5, 8'hA5));
        run_queues();
        forced_delay = -1;

        forced_rdata = 8'h3C;
        q1.push_back(mk(0, 0, 319, 239, 0));
        run_queues();
        forced_rdata = -1;

        q0.push_back(mk(1, 0, 320, 0, 8'h11));
        run_queues();
        q1.push_back(mk(0, 0, 5, 240, 0));
        run_queues();
        q0.push_back(mk(1, 1, 7, 9, 8'h5A));
        run_queues();

        for (int r = 0; r < 40; r++) begin
            int n0, n1;
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) q0.push_back(rand_op());
            for (int i = 0; i < n1; i++) q1.push_back(rand_op());
            run_queues();
        end

        // Reset in the middle of an access the memory never completes.
        q0.push_back(mk(1, 0, 50, 60, 8'h77));
        drive_clients();
        for (int i = 0; i < 10 && !memoryWriteRequest; i++) begin
            @(posedge clock);
            #1;
        end
        check_eq("rst_mid_reached_issue", 32'(memoryWriteRequest), 32'(1));
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        q0.delete();
        drive_clients();
        model_last = 1'b1;
        exp_rd0    = 8'h00;
        exp_rd1    = 8'h00;
        check_eq("rst_mid_req_low", 32'({memoryReadRequest, memoryWriteRequest}), 32'(0));
        check_eq("rst_mid_busy", 32'(busy), 32'(0));
        check_eq("rst_mid_no_cmp",
                 32'({c0ReadComplete, c0WriteComplete, c1ReadComplete, c1WriteComplete}), 32'(0));
        @(posedge clock);
        #1;
        check_eq("rst_mid_still_quiet",
                 32'({c0ReadComplete, c0WriteComplete, c1ReadComplete, c1WriteComplete, busy}), 32'(0));
        q0.push_back(mk(1, 0, 33, 44, 8'hC3));
        q0.push_back(mk(0, 0, 33, 44, 0));
        run_queues();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
